// File: rtl/shift_stage_pkg.sv
// shift_stage_pkg: operand widths and shift op encodings shared by the shift stage
package shift_stage_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;
    localparam int OP_W   = 2;

    localparam logic [OP_W-1:0] OP_SRA = 2'b00;
    localparam logic [OP_W-1:0] OP_SRL = 2'b01;
    localparam logic [OP_W-1:0] OP_ROL = 2'b10;
    localparam logic [OP_W-1:0] OP_SLL = 2'b11;

endpackage

// File: rtl/shift_stage_shifter.sv
// shift_stage_shifter: 16-bit combinational barrel shifter (SRA, SRL, ROL, SLL)
module shift_stage_shifter
    import shift_stage_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic [OP_W-1:0]   op_i,
    output logic [DATA_W-1:0] res_o
);

    logic [DATA_W-1:0]   sra;
    logic [2*DATA_W-1:0] dbl;

    // Rotate is taken from the upper half of the doubled operand shifted left
    always_comb begin
        sra   = DATA_W'($signed(data_i) >>> cnt_i);
        dbl   = {data_i, data_i} << cnt_i;
        res_o = (op_i == OP_SRA) ? sra :
                (op_i == OP_SRL) ? data_i >> cnt_i :
                (op_i == OP_ROL) ? dbl[2*DATA_W-1:DATA_W] :
                                   data_i << cnt_i;
    end

endmodule

// File: rtl/shift_stage.sv
// shift_stage: request FIFO feeding a barrel shifter with a registered, back-pressured output
module shift_stage
    import shift_stage_pkg::*;
#(
    parameter int TAG_W = 3,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_data,
    input  logic [3:0]                 in_cnt,
    input  logic [1:0]                 in_op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_zero,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [CNT_W-1:0]  cnt_q  [DEPTH];
    logic [CNT_W-1:0]  cnt_d  [DEPTH];
    logic [OP_W-1:0]   op_q   [DEPTH];
    logic [OP_W-1:0]   op_d   [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              out_zero_q, out_zero_d;

    logic              push, pop;
    logic [DATA_W-1:0] sh_res;

    // Acceptance depends only on occupancy so in_ready never combinationally follows out_ready
    assign in_ready  = occ_q < OCC_W'(DEPTH);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = (occ_q != '0) && (!out_valid_q || out_ready) && !flush;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_zero  = out_zero_q;
    assign occupancy = occ_q;

    shift_stage_shifter shifter (
        .data_i (data_q[rd_ptr_q]),
        .cnt_i  (cnt_q[rd_ptr_q]),
        .op_i   (op_q[rd_ptr_q]),
        .res_o  (sh_res)
    );

    // Next state: FIFO write at tail, head result into the output register on pop, flush clears control
    always_comb begin
        data_d      = data_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        tag_d       = tag_q;
        if (push) begin
            data_d[wr_ptr_q] = in_data;
            cnt_d[wr_ptr_q]  = in_cnt;
            op_d[wr_ptr_q]   = in_op;
            tag_d[wr_ptr_q]  = in_tag;
        end
        wr_ptr_d    = flush ? '0 : push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = flush ? '0 : pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d       = flush ? '0 : occ_q + OCC_W'(push) - OCC_W'(pop);
        out_valid_d = flush ? 1'b0 : pop ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
        out_data_d  = pop ? sh_res : out_data_q;
        out_tag_d   = pop ? tag_q[rd_ptr_q] : out_tag_q;
        out_zero_d  = pop ? (sh_res == '0) : out_zero_q;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '{default: '0};
            cnt_q       <= '{default: '0};
            op_q        <= '{default: '0};
            tag_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_zero_q  <= out_zero_d;
        end
    end

endmodule

// File: tb/tb_shift_stage.sv
// tb_shift_stage: directed table-driven checks of the shift stage plus backpressure, flush and reset sequences
module tb_shift_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_cnt;
    logic [1:0]  in_op;
    logic [2:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_tag;
    logic        out_zero;
    logic [1:0]  occupancy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_stage #(.TAG_W(3), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero),
        .occupancy (occupancy)
    );

    typedef struct {
        logic [15:0] d;
        logic [3:0]  c;
        logic [1:0]  op;
        logic [2:0]  tag;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] c,
                         input logic [1:0] op, input logic [2:0] tag);
        in_valid = v;
        in_data  = d;
        in_cnt   = c;
        in_op    = op;
        in_tag   = tag;
    endtask

    // Three pushes with out_ready low: one lands in the output register, two fill the FIFO
    task automatic fill3();
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 16'h8001, 4'd1, 2'b00, 3'd1);
        @(negedge clk);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        drive(1'b1, 16'h0003, 4'd2, 2'b11, 3'd2);
        @(negedge clk);
        chk("bp_ready2", 32'(in_ready), 32'd1);
        drive(1'b1, 16'h00F0, 4'd4, 2'b01, 3'd3);
        @(negedge clk);
        drive(1'b0, 16'h0, 4'd0, 2'b00, 3'd0);
    endtask

    logic [15:0] seen_d [8];
    logic [2:0]  seen_t [8];
    int          seen_c [8];
    int          n;
    logic [15:0] held;

    initial begin
        vt[0]  = '{16'h8001, 4'd1,  2'b00, 3'd5, 16'hC000};
        vt[1]  = '{16'h8001, 4'd4,  2'b10, 3'd1, 16'h0018};
        vt[2]  = '{16'h00FF, 4'd8,  2'b11, 3'd2, 16'hFF00};
        vt[3]  = '{16'hF000, 4'd15, 2'b01, 3'd3, 16'h0001};
        vt[4]  = '{16'h0001, 4'd0,  2'b11, 3'd4, 16'h0001};
        vt[5]  = '{16'h8000, 4'd1,  2'b11, 3'd6, 16'h0000};
        vt[6]  = '{16'h8000, 4'd15, 2'b00, 3'd7, 16'hFFFF};
        vt[7]  = '{16'h7FFF, 4'd15, 2'b00, 3'd0, 16'h0000};
        vt[8]  = '{16'h8000, 4'd0,  2'b01, 3'd1, 16'h8000};
        vt[9]  = '{16'h1234, 4'd8,  2'b10, 3'd2, 16'h3412};
        vt[10] = '{16'h8000, 4'd15, 2'b10, 3'd3, 16'h4000};
        vt[11] = '{16'h4000, 4'd3,  2'b00, 3'd4, 16'h0800};
        vt[12] = '{16'hFFFF, 4'd15, 2'b11, 3'd5, 16'h8000};
        vt[13] = '{16'h1234, 4'd4,  2'b01, 3'd6, 16'h0123};
        vt[14] = '{16'h0001, 4'd15, 2'b10, 3'd7, 16'h8000};

        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 4'd0, 2'b00, 3'd0);
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_zero", 32'(out_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Single requests: result visible after the second edge following the push
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, vt[i].d, vt[i].c, vt[i].op, vt[i].tag);
            @(negedge clk);
            drive(1'b0, 16'h0, 4'd0, 2'b00, 3'd0);
            chk("lat_not_yet", 32'(out_valid), 32'd0);
            @(negedge clk);
            chk("vec_valid", 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vt[i].exp));
            chk($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(vt[i].tag));
            chk($sformatf("vec%0d_zero", i), 32'(out_zero), 32'(vt[i].exp == 16'h0));
            @(negedge clk);
            chk("vec_drained", 32'(out_valid), 32'd0);
        end

        // Back-to-back ops, one result per cycle
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid && n < 8) begin
                seen_d[n] = out_data;
                seen_c[n] = k;
                n++;
            end
            if (k < 4) drive(1'b1, vt[k+1].d, vt[k+1].c, vt[k+1].op, vt[k+1].tag);
            else drive(1'b0, 16'h0, 4'd0, 2'b00, 3'd0);
            @(negedge clk);
        end
        chk("b2b_count", 32'(n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b2b%0d_data", k), 32'(seen_d[k]), 32'(vt[k+1].exp));
            chk($sformatf("b2b%0d_cycle", k), 32'(seen_c[k] - seen_c[0]), 32'(k));
        end

        // Backpressure: in_ready drops with two queued and one held, output stable
        fill3();
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        chk("bp_occ", 32'(occupancy), 32'd2);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_head", 32'(out_data), 32'hC000);
        held = out_data;
        drive(1'b1, 16'hAAAA, 4'd1, 2'b01, 3'd7);
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 16'h0, 4'd0, 2'b00, 3'd0);
        chk("bp_stable", 32'(out_data), 32'(held));
        chk("bp_stable_tag", 32'(out_tag), 32'd1);
        chk("bp_no_overflow", 32'(occupancy), 32'd2);
        out_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid && out_ready && n < 8) begin
                seen_d[n] = out_data;
                seen_t[n] = out_tag;
                n++;
            end
            @(negedge clk);
        end
        chk("drain_count", 32'(n), 32'd3);
        chk("drain0", 32'({seen_t[0], seen_d[0]}), 32'({3'd1, 16'hC000}));
        chk("drain1", 32'({seen_t[1], seen_d[1]}), 32'({3'd2, 16'h000C}));
        chk("drain2", 32'({seen_t[2], seen_d[2]}), 32'({3'd3, 16'h000F}));
        chk("drain_occ", 32'(occupancy), 32'd0);

        // Flush with a full FIFO and a held output, in_valid ignored
        fill3();
        flush = 1'b1;
        drive(1'b1, 16'h5555, 4'd1, 2'b11, 3'd5);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 16'h0, 4'd0, 2'b00, 3'd0);
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("fl_nothing", 32'(n), 32'd0);

        // Asynchronous reset mid-stream
        fill3();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_occ", 32'(occupancy), 32'd0);
        chk("ar_data", 32'(out_data), 32'd0);
        chk("ar_tag", 32'(out_tag), 32'd0);
        chk("ar_zero", 32'(out_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("ar_nothing", 32'(n), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd1);

        // Fresh push after reset still works
        drive(1'b1, 16'h8000, 4'd1, 2'b11, 3'd2);
        @(negedge clk);
        drive(1'b0, 16'h0, 4'd0, 2'b00, 3'd0);
        @(negedge clk);
        chk("post_valid", 32'(out_valid), 32'd1);
        chk("post_zero", 32'({out_zero, out_data}), 32'({1'b1, 16'h0000}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/shift_stage.md
SHIFT_STAGE -- requirements
Module: shift_stage

Interface
REQ-001 Parameter TAG_W, default 3: width of the request tag carried alongside each shift.
REQ-002 Parameter DEPTH, default 2: request FIFO entries; legal values are 2 and 4 only.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 flush  input  1: synchronous discard of all queued and output-held work.
REQ-006 in_valid  input  1: the upstream request is present.
REQ-007 in_ready  output  1: the block can accept a request this cycle.
REQ-008 in_data  input  16: the operand to shift.
REQ-009 in_cnt  input  4: the shift amount, 0-15.
REQ-010 in_op  input  2: the operation; 00 SRA, 01 SRL, 10 ROL, 11 SLL.
REQ-011 in_tag  input  TAG_W: an opaque tag, returned with the result.
REQ-012 out_valid  output  1: a result is held.
REQ-013 out_ready  input  1: downstream accepts the result.
REQ-014 out_data  output  16: the shifted result.
REQ-015 out_tag  output  TAG_W: the tag of the result.
REQ-016 out_zero  output  1: out_data == 16'h0000.
REQ-017 occupancy  output  $clog2(DEPTH)+1: the number of FIFO entries in use.

Function
REQ-018 A push occurs when in_valid && in_ready && !flush; the request is written at the tail of the FIFO.
- in_ready = (occupancy < DEPTH).
- in_ready is not combinationally dependent on out_ready.
REQ-019 The combinational shift result is computed from the FIFO head {data,cnt,op}.
- SRA fills with bit 15.
- SRL and SLL fill with zeros.
- ROL rotates left.
- cnt 0 returns the operand unchanged for all ops.
REQ-020 A pop occurs when occupancy>0 && (!out_valid || out_ready) && !flush.
- The head result, tag and zero flag load into the output register, and out_valid is set.
REQ-021 If out_valid && out_ready and no pop occurs, out_valid clears on the next edge.
REQ-022 Latency: a request pushed at edge N into an empty block with a free output has out_valid high after edge N+1. The sustained throughput is 1 result per cycle with out_ready held high.
REQ-023 Simultaneous push and pop: occupancy is unchanged and ordering is strictly FIFO. A push into a full FIFO cannot occur.
REQ-024 Pointers wrap modulo DEPTH. Occupancy ranges 0..DEPTH and never under- or overflows.
REQ-025 out_valid held high with out_ready low: out_data, out_tag and out_zero stay stable until accepted.
REQ-026 flush takes priority over push and pop. On the next edge, occupancy is 0, out_valid is 0 and the pointers are 0; in_valid during flush is ignored.
REQ-027 There is no state machine beyond the FIFO occupancy and the out_valid bit. Control is fully determined by occupancy, out_valid, the handshakes and flush.

Reset
REQ-028 While rst_n is low, the following hold asynchronously: out_valid=0, occupancy=0, pointers=0, out_data=16'h0000, out_tag=0, out_zero=0.
- in_ready=1 once rst_n is deasserted.
REQ-029 Reset asserted mid-operation discards all pending requests. No result appears after reset release without a new push.

Structure
REQ-030 The op encodings (SRA, SRL, ROL, SLL) shall be constants in the shared package.
REQ-031 The result computation shall be one instance of the team's existing 16-bit combinational barrel shifter sub-module, named shifter. It is not re-implemented inline.
REQ-032 The FIFO storage and pointers live in shift_stage. No further sub-modules are used.

Verification
REQ-033 SRA: push 16'h8001, cnt 1, op 00, tag 5 -> out_data 16'hC000, out_tag 5, out_zero 0, out_valid on the second edge after the push.
REQ-034 Ops: push ROL 16'h8001 cnt 4, then SLL 16'h00FF cnt 8, then SRL 16'hF000 cnt 15, then SLL 16'h0001 cnt 0, all back-to-back with out_ready=1 -> in order 16'h0018, 16'hFF00, 16'h0001, 16'h0001, one per cycle.
REQ-035 Zero flag: push SLL 16'h8000 cnt 1 -> out_data 16'h0000 and out_zero 1.
REQ-036 Backpressure: hold out_ready=0 and push 3 requests with DEPTH=2 -> in_ready falls after 2 FIFO pushes plus 1 held output, and out_data is stable. Then release out_ready -> all 3 drain in order with no loss or duplication.
REQ-037 Flush/reset: with a full FIFO and out_valid=1, assert flush with in_valid=1 -> next cycle occupancy 0, out_valid 0, nothing emitted. Repeat with rst_n pulsed low mid-stream -> the same outcome, taking effect asynchronously.
